global_magic_responder: RTL and testbench
=========================================

# global_magic_responder

Responder side of the compute group's global-memory interface. Accepts one bundled request per `GLOBAL_EN` pulse: five read addresses (A, B, C, 0, 1) and one optional write (W). Services the request serially against a single-port global RAM, holding `STALL_GLOB` high until all results are ready. Sits between one `Compute_Group` and the shared global memory; its ports mirror that group's global-side ports.

## Interface
- `GM_AW`, 10: log2 of global RAM depth in 32-bit words (default 1024 words).
- `GLOBAL_BASE`, 32'h0000_1000: first word address owned by global memory; RAM index = address − `GLOBAL_BASE`.
- `CLK` in 1: single clock, rising edge.
- `RESET_n` in 1: reset is asynchronous and active-low.
- `GLOBAL_EN` in 1: request strobe from the compute group.
- `ADDRESS_A`, `ADDRESS_B`, `ADDRESS_C`, `ADDRESS_0`, `ADDRESS_1` in 32 each: read addresses.
- `ADDRESS_W` in 32: write address.
- `DATA_TO_W` in 32: write data.
- `W_EN` in 1: write qualifier, sampled with `GLOBAL_EN`.
- `DATA_OUT_A`, `DATA_OUT_B`, `DATA_OUT_C`, `DATA_OUT_0`, `DATA_OUT_1` out 32 each: read results, registered.
- `STALL_GLOB` out 1: busy/stall to the compute group.
- `GM_ERR` out 1: sticky out-of-window flag (see Configuration).

## Operation
- **Reset values:** all `DATA_OUT_*` = 0, `STALL_GLOB` = 0, `GM_ERR` = 0, state = IDLE. RAM contents are not cleared.
- **States:** IDLE → RD → RD_LAST → (WR) → IDLE.
- **IDLE, `GLOBAL_EN`=0:** no action.
- **IDLE, `GLOBAL_EN`=1 at a rising edge:**
  - Capture all six addresses, `DATA_TO_W` and `W_EN` into request registers.
  - Go to RD with slot counter = 0.
- **RD (5 cycles):** issue a RAM read for slot k (order A, B, C, 0, 1). Capture the RAM output for slot k−1 into `DATA_OUT_*`. After k=4, go to RD_LAST.
- **RD_LAST:** capture slot 1 data. Go to WR if captured `W_EN`=1, else IDLE.
- **WR:** write captured data to the captured W index. Go to IDLE.
- **Ordering:** reads return pre-write contents. A read of the same word as W in one request returns the old value.
- **During busy:** `GLOBAL_EN` is ignored in every non-IDLE state (no queueing). A request in the first IDLE cycle after completion is accepted.
- **Output stability:** `DATA_OUT_*` change only during RD/RD_LAST captures and hold until the next request.
- **Reset mid-request:** abort immediately to IDLE with reset output values. A pending write is dropped.

## Timing
- **`STALL_GLOB`:**
  - Combinationally high in IDLE while `GLOBAL_EN`=1, so the request cycle itself stalls.
  - Registered high in RD, RD_LAST and WR.
- **Stall length**, counting the request cycle as cycle 0:
  - Without write: cycles 0–6 (7 cycles).
  - With write: cycles 0–7 (8 cycles).
- **Data valid:** all `DATA_OUT_*` are valid at the first edge where `STALL_GLOB` is sampled low after a request.
- **RAM:** synchronous read, 1-cycle latency, single port. Only one access is issued per cycle.

## Configuration
- **`PURISC_GM_BOUNDS_CHECK_EN` defined:**
  - An address outside [`GLOBAL_BASE`, `GLOBAL_BASE` + 2^`GM_AW`) reads 32'hDEAD_BEEF and a write to it is dropped.
  - Either case sets `GM_ERR`, which stays high until reset.
- **Undefined:**
  - The index is (address − `GLOBAL_BASE`) modulo 2^`GM_AW` (wrap-around). All accesses proceed.
  - `GM_ERR` is tied 0.

## Structure
- **Package `gm_pkg`:**
  - State enum `gm_state_t` (IDLE, RD, RD_LAST, WR).
  - Slot index constants SLOT_A..SLOT_1 = 0..4.
  - Default `GLOBAL_BASE`.
  - Error pattern 32'hDEAD_BEEF.
- **Sub-module `gm_ram`:** single-port synchronous RAM, parameter `GM_AW`, ports `CLK`/addr/wdata/we/rdata. It has no reset and accepts an optional `$readmemh` init file for benches.

## Test plan
- **Reset:** hold `RESET_n`=0 with `GLOBAL_EN`=1 → all `DATA_OUT_*`=0, `STALL_GLOB`=0. After release, `GLOBAL_EN` pulses are serviced normally.
- **Plain read:** preload RAM[0..4]=10,11,12,13,14; request with addresses 0x1000..0x1004, `W_EN`=0 → stall exactly 7 cycles, then `DATA_OUT_A..1`=10..14.
- **Write then read-back:** request W=0x1002, data 0x55, `W_EN`=1, A=0x1002 → 8-cycle stall, `DATA_OUT_A`=12 (old value). The next request reading 0x1002 → 0x55.
- **Busy and back-to-back:** toggle `GLOBAL_EN` during stall → no extra request, no output change. Assert it again in the first IDLE cycle → second request accepted, stall resumes same cycle.
- **Reset mid-request:** drop `RESET_n` in RD cycle 3 of a write request → outputs reset, target word unchanged afterwards.
- **Out-of-window address:** A=0x0000_0FFF, W=0x2000_0000.
  - With `PURISC_GM_BOUNDS_CHECK_EN`: `DATA_OUT_A`=0xDEAD_BEEF, `GM_ERR`=1 and stays high, no write.
  - Without it: wrapped index accessed (A → RAM[1023]), `GM_ERR`=0.

Source files
------------

// File: rtl/global_magic_responder_pkg.sv
// Shared types and constants for the global-memory responder (package gm_pkg).
// Optional feature macro: PURISC_GM_BOUNDS_CHECK_EN (address window checking).
package gm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        RD_LAST = 2'd2,
        WR      = 2'd3
    } gm_state_t;

    // Read slots in the order they are issued to the RAM.
    localparam int SLOT_A    = 0;
    localparam int SLOT_B    = 1;
    localparam int SLOT_C    = 2;
    localparam int SLOT_0    = 3;
    localparam int SLOT_1    = 4;
    localparam int NUM_SLOTS = 5;

    localparam logic [31:0] GM_GLOBAL_BASE = 32'h0000_1000;
    localparam logic [31:0] GM_ERR_PATTERN = 32'hDEAD_BEEF;

    // True when addr falls inside [base, base + 2^aw).
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/global_magic_responder_if.sv
// Bundle of the compute group's global-side request/response signals.
// Protocol: the compute group pulses GLOBAL_EN with all addresses, DATA_TO_W
// and W_EN valid in the same cycle; the responder raises STALL_GLOB in that
// cycle and keeps it high until every DATA_OUT_* is valid. GLOBAL_EN is only
// honoured while the responder is idle; DATA_OUT_* are valid at the first
// rising edge where STALL_GLOB is sampled low.
interface global_magic_responder_if;
    logic        GLOBAL_EN;
    logic [31:0] ADDRESS_A;
    logic [31:0] ADDRESS_B;
    logic [31:0] ADDRESS_C;
    logic [31:0] ADDRESS_0;
    logic [31:0] ADDRESS_1;
    logic [31:0] ADDRESS_W;
    logic [31:0] DATA_TO_W;
    logic        W_EN;
    logic [31:0] DATA_OUT_A;
    logic [31:0] DATA_OUT_B;
    logic [31:0] DATA_OUT_C;
    logic [31:0] DATA_OUT_0;
    logic [31:0] DATA_OUT_1;
    logic        STALL_GLOB;
    logic        GM_ERR;

    modport master (
        output GLOBAL_EN, ADDRESS_A, ADDRESS_B, ADDRESS_C, ADDRESS_0, ADDRESS_1,
               ADDRESS_W, DATA_TO_W, W_EN,
        input  DATA_OUT_A, DATA_OUT_B, DATA_OUT_C, DATA_OUT_0, DATA_OUT_1,
               STALL_GLOB, GM_ERR
    );

    modport slave (
        input  GLOBAL_EN, ADDRESS_A, ADDRESS_B, ADDRESS_C, ADDRESS_0, ADDRESS_1,
               ADDRESS_W, DATA_TO_W, W_EN,
        output DATA_OUT_A, DATA_OUT_B, DATA_OUT_C, DATA_OUT_0, DATA_OUT_1,
               STALL_GLOB, GM_ERR
    );
endinterface

// File: rtl/global_magic_responder_ram.sv
// Single-port synchronous global RAM (module gm_ram), read-first, 1-cycle
// read latency, no reset on contents.
module gm_ram #(
    parameter int unsigned GM_AW = 10
) (
    input  logic             CLK,
    input  logic [GM_AW-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**GM_AW];

    // One access per cycle: optional write plus registered read of the old word.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/global_magic_responder.sv
// Serial responder: services one bundled request (five reads, optional write)
// against a single-port global RAM while holding STALL_GLOB high.
// Optional feature macro: PURISC_GM_BOUNDS_CHECK_EN -- out-of-window reads
// return GM_ERR_PATTERN, out-of-window writes are dropped, GM_ERR is sticky.
// Without it, indices wrap modulo 2^GM_AW and GM_ERR is tied low.
module global_magic_responder
    import gm_pkg::*;
#(
    parameter int unsigned GM_AW       = 10,
    parameter logic [31:0] GLOBAL_BASE = GM_GLOBAL_BASE
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    global_magic_responder_if.slave gm,
    output gm_state_t               dbg_state
);

    gm_state_t        state_q, state_d;
    logic [2:0]       slot_q;
    logic [31:0]      req_addr [NUM_SLOTS];
    logic [31:0]      req_waddr;
    logic [31:0]      req_wdata;
    logic             req_we;
    logic [31:0]      data_q [NUM_SLOTS];
    logic [GM_AW-1:0] ram_addr;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic             cap_en;
    logic [2:0]       cap_slot;
    logic [31:0]      cap_data;
    logic [31:0]      rd_addr;
    logic             wr_ok;

    assign rd_addr = req_addr[slot_q];

`ifdef PURISC_GM_BOUNDS_CHECK_EN
    logic err_q;
    assign wr_ok    = in_window(req_waddr, GLOBAL_BASE, GM_AW);
    assign cap_data = in_window(req_addr[cap_slot], GLOBAL_BASE, GM_AW) ? ram_rdata
                                                                        : GM_ERR_PATTERN;
    assign gm.GM_ERR = err_q;

    // Sticky error: set whenever an out-of-window read or write is issued.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            err_q <= 1'b0;
        end else if ((state_q == RD && !in_window(rd_addr, GLOBAL_BASE, GM_AW)) ||
                     (state_q == WR && !wr_ok)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wr_ok     = 1'b1;
    assign cap_data  = ram_rdata;
    assign gm.GM_ERR = 1'b0;
`endif

    // Next-state, RAM port and capture-slot selection.
    always_comb begin
        state_d  = state_q;
        ram_addr = GM_AW'(rd_addr - GLOBAL_BASE);
        ram_we   = 1'b0;
        cap_en   = 1'b0;
        cap_slot = 3'd0;
        case (state_q)
            IDLE: begin
                if (gm.GLOBAL_EN) state_d = RD;
            end
            RD: begin
                // Slot k is read now; slot k-1's data is on the RAM output.
                cap_en   = (slot_q != 3'(SLOT_A));
                cap_slot = slot_q - 3'd1;
                if (slot_q == 3'(SLOT_1)) state_d = RD_LAST;
            end
            RD_LAST: begin
                cap_en   = 1'b1;
                cap_slot = 3'(SLOT_1);
                state_d  = req_we ? WR : IDLE;
            end
            WR: begin
                ram_addr = GM_AW'(req_waddr - GLOBAL_BASE);
                ram_we   = wr_ok;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request capture, slot counter and result registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            slot_q    <= 3'd0;
            req_waddr <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                req_addr[i] <= '0;
                data_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gm.GLOBAL_EN) begin
                req_addr[SLOT_A] <= gm.ADDRESS_A;
                req_addr[SLOT_B] <= gm.ADDRESS_B;
                req_addr[SLOT_C] <= gm.ADDRESS_C;
                req_addr[SLOT_0] <= gm.ADDRESS_0;
                req_addr[SLOT_1] <= gm.ADDRESS_1;
                req_waddr        <= gm.ADDRESS_W;
                req_wdata        <= gm.DATA_TO_W;
                req_we           <= gm.W_EN;
                slot_q           <= 3'd0;
            end
            // Counter stops at the last slot so it always indexes a valid slot.
            if (state_q == RD && slot_q != 3'(SLOT_1)) begin
                slot_q <= slot_q + 3'd1;
            end
            if (cap_en) begin
                data_q[cap_slot] <= cap_data;
            end
        end
    end

    gm_ram #(.GM_AW(GM_AW)) u_ram (
        .CLK   (CLK),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .we    (ram_we),
        .rdata (ram_rdata)
    );

    // Request cycle stalls combinationally; reset forces the stall low.
    assign gm.STALL_GLOB = (state_q != IDLE) || (gm.GLOBAL_EN && RESET_n);
    assign gm.DATA_OUT_A = data_q[SLOT_A];
    assign gm.DATA_OUT_B = data_q[SLOT_B];
    assign gm.DATA_OUT_C = data_q[SLOT_C];
    assign gm.DATA_OUT_0 = data_q[SLOT_0];
    assign gm.DATA_OUT_1 = data_q[SLOT_1];
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_global_magic_responder.sv
// Bench for global_magic_responder: randomized requests against a memory
// model, expected results queued at issue time and checked by a monitor.
// Optional feature macro: PURISC_GM_BOUNDS_CHECK_EN (model follows it).
module tb_global_magic_responder;
  import gm_pkg::*;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef PURISC_GM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic [4:0][31:0] data;
    logic [4:0]       chk;
    logic             err;
    logic [3:0]       len;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  gm_state_t dbg_state;

  global_magic_responder_if gm_if();

  global_magic_responder #(.GM_AW(AW), .GLOBAL_BASE(BASE)) dut (
    .CLK       (clk),
    .RESET_n   (rst_n),
    .gm        (gm_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  bit          err_m = 1'b0;
  bit          mon_busy = 1'b0;
  string       slot_name [5] = '{"data_A", "data_B", "data_C", "data_0", "data_1"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + DEPTH);
  endfunction

  function automatic int wrap_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d % DEPTH);
  endfunction

  function automatic exp_t model_request(input logic [4:0][31:0] addrs, input logic [31:0] wa,
                                         input logic [31:0] wd, input logic we);
    exp_t e;
    int   idx;
    e = '0;
    for (int i = 0; i < 5; i++) begin
      if (BOUNDS && !in_win(addrs[i])) begin
        e.data[i] = 32'hDEAD_BEEF;
        e.chk[i]  = 1'b1;
        err_m     = 1'b1;
      end else begin
        idx       = wrap_idx(addrs[i]);
        e.data[i] = mem_m[idx];
        e.chk[i]  = known_m[idx];
      end
    end
    if (we) begin
      if (BOUNDS && !in_win(wa)) begin
        err_m = 1'b1;
      end else begin
        idx          = wrap_idx(wa);
        mem_m[idx]   = wd;
        known_m[idx] = 1'b1;
      end
    end
    e.err = err_m;
    e.len = we ? 4'd8 : 4'd7;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input logic [4:0][31:0] addrs, input logic [31:0] wa,
                              input logic [31:0] wd, input logic we);
    gm_if.ADDRESS_A = addrs[0];
    gm_if.ADDRESS_B = addrs[1];
    gm_if.ADDRESS_C = addrs[2];
    gm_if.ADDRESS_0 = addrs[3];
    gm_if.ADDRESS_1 = addrs[4];
    gm_if.ADDRESS_W = wa;
    gm_if.DATA_TO_W = wd;
    gm_if.W_EN      = we;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the
  // edge that starts the first idle cycle following the request.
  task automatic issue(input logic [4:0][31:0] addrs, input logic [31:0] wa,
                       input logic [31:0] wd, input logic we, input bit toggle);
    exp_t e;
    logic [4:0][31:0] junk;
    e = model_request(addrs, wa, wd, we);
    drive_inputs(addrs, wa, wd, we);
    gm_if.GLOBAL_EN = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    gm_if.GLOBAL_EN = 1'b0;
    for (int c = 1; c < int'(e.len); c++) begin
      if (toggle) begin
        for (int i = 0; i < 5; i++) junk[i] = $urandom;
        drive_inputs(junk, $urandom, $urandom, 1'($urandom_range(0, 1)));
        gm_if.GLOBAL_EN = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    gm_if.GLOBAL_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return BASE + 32'(r);
    if (r == 16) return BASE + 32'(DEPTH - 1);
    if (r == 17) return 32'h0000_0FFF;
    if (r == 18) return 32'h2000_0000;
    return BASE + 32'($urandom_range(0, 15));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_A"}, gm_if.DATA_OUT_A, 32'h0);
    check({tag, "_out_B"}, gm_if.DATA_OUT_B, 32'h0);
    check({tag, "_out_C"}, gm_if.DATA_OUT_C, 32'h0);
    check({tag, "_out_0"}, gm_if.DATA_OUT_0, 32'h0);
    check({tag, "_out_1"}, gm_if.DATA_OUT_1, 32'h0);
    check({tag, "_stall"}, 32'(gm_if.STALL_GLOB), 32'h0);
    check({tag, "_err"}, 32'(gm_if.GM_ERR), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- monitor ----------------
  exp_t mon_cur;
  int   mon_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
    end else if (!mon_busy) begin
      if (gm_if.STALL_GLOB) begin
        if (exp_q.size() == 0) begin
          check("spurious_stall", 32'(gm_if.STALL_GLOB), 32'h0);
        end else begin
          mon_cur  = exp_q[0];
          mon_busy = 1'b1;
          mon_cnt  = 1;
        end
      end
    end else if (mon_cnt < int'(mon_cur.len)) begin
      check("stall_held", 32'(gm_if.STALL_GLOB), 32'h1);
      mon_cnt++;
    end else begin
      void'(exp_q.pop_front());
      if (mon_cur.chk[0]) check(slot_name[0], gm_if.DATA_OUT_A, mon_cur.data[0]);
      if (mon_cur.chk[1]) check(slot_name[1], gm_if.DATA_OUT_B, mon_cur.data[1]);
      if (mon_cur.chk[2]) check(slot_name[2], gm_if.DATA_OUT_C, mon_cur.data[2]);
      if (mon_cur.chk[3]) check(slot_name[3], gm_if.DATA_OUT_0, mon_cur.data[3]);
      if (mon_cur.chk[4]) check(slot_name[4], gm_if.DATA_OUT_1, mon_cur.data[4]);
      check("gm_err", 32'(gm_if.GM_ERR), 32'(mon_cur.err));
      mon_busy = 1'b0;
      if (gm_if.STALL_GLOB) begin
        if (exp_q.size() == 0) begin
          check("stall_too_long", 32'(gm_if.STALL_GLOB), 32'h0);
        end else begin
          mon_cur  = exp_q[0];
          mon_busy = 1'b1;
          mon_cnt  = 1;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0][31:0] a;
    int               wait_cycles;

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) a[i] = BASE;
    drive_inputs(a, BASE, 32'h0, 1'b0);

    // Reset held with a request strobe present.
    gm_if.GLOBAL_EN = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    gm_if.GLOBAL_EN = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Preload the word pool through ordinary write requests.
    for (int i = 0; i < 16; i++) begin
      issue(a, BASE + 32'(i), (i < 5) ? 32'(10 + i) : $urandom, 1'b1, 1'b0);
      idle(1);
    end
    issue(a, BASE + 32'(DEPTH - 1), $urandom, 1'b1, 1'b0);
    idle(1);

    // Plain read of words 0..4.
    for (int i = 0; i < 5; i++) a[i] = BASE + 32'(i);
    issue(a, BASE, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Write then read-back of the same word.
    a[0] = BASE + 32'h2;
    issue(a, BASE + 32'h2, 32'h55, 1'b1, 1'b0);
    idle(1);
    issue(a, BASE, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Strobe toggled while busy, then a request in the first idle cycle.
    for (int i = 0; i < 5; i++) a[i] = BASE + 32'(5 + i);
    issue(a, BASE + 32'h9, 32'h1234_5678, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) a[i] = BASE + 32'(9 - i);
    issue(a, BASE, 32'h0, 1'b0, 1'b1);
    issue(a, BASE + 32'h3, 32'hCAFE_0003, 1'b1, 1'b0);
    idle(2);

    // Reset in the third read cycle of a write request: write must be dropped.
    for (int i = 0; i < 5; i++) a[i] = BASE;
    drive_inputs(a, BASE + 32'h7, 32'hABCD_0123, 1'b1);
    gm_if.GLOBAL_EN = 1'b1;
    exp_q.push_back('{data: '0, chk: '0, err: 1'b0, len: 4'd8});
    @(posedge clk); #1;
    gm_if.GLOBAL_EN = 1'b0;
    idle(2);
    rst_n = 1'b0;
    exp_q.delete();
    err_m = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) a[i] = BASE + 32'h7;
    issue(a, BASE, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Out-of-window read and write.
    a[0] = 32'h0000_0FFF;
    for (int i = 1; i < 5; i++) a[i] = BASE + 32'(i);
    issue(a, 32'h2000_0000, 32'h0000_0077, 1'b1, 1'b0);
    idle(3);
    check("gm_err_sticky", 32'(gm_if.GM_ERR), 32'(BOUNDS));
    for (int i = 0; i < 5; i++) a[i] = BASE + 32'(i);
    issue(a, BASE, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Randomized traffic, including back-to-back and strobes while busy.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 5; i++) a[i] = pick_addr();
      issue(a, pick_addr(), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end

    // Drain with a bounded wait.
    wait_cycles = 0;
    while ((exp_q.size() != 0 || mon_busy) && wait_cycles < 40) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("monitor_idle", 32'(mon_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
